// File: rtl/wd_pkg.sv
// Shared definitions for the watchdog feeder: FSM state encoding, trip counter
// width and the default timing constants also used by the watchdog block.
package wd_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_RUN      = 3'd1,
    ST_FEED     = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_HOLDOFF  = 3'd4
  } wd_state_e;

  localparam int TRIP_W = 8;

  localparam int DEF_N_SRC          = 4;
  localparam int DEF_FEED_PERIOD    = 1000;
  localparam int DEF_FEED_WIDTH     = 2;
  localparam int DEF_HB_WINDOW      = 2000;
  localparam int DEF_RECOVER_CYCLES = 16;

endpackage

// File: rtl/wd_hb_mon.sv
// One heartbeat window counter: counts idle cycles while active and raises the
// stale flag once the count saturates at HB_WINDOW.
module wd_hb_mon
  import wd_pkg::*;
#(
  parameter int HB_WINDOW = DEF_HB_WINDOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic act_i,
  input  logic hb_i,
  output logic stale_o
);

  localparam int CW = $clog2(HB_WINDOW + 1);
  localparam logic [CW-1:0] WIN = CW'(HB_WINDOW);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stale_q, stale_d;

  // A strobe in the same cycle the window closes wins over going stale.
  always_comb begin
    cnt_d   = cnt_q;
    stale_d = stale_q;
    if (clr_i) begin
      cnt_d   = '0;
      stale_d = 1'b0;
    end else if (act_i) begin
      if (hb_i) begin
        cnt_d   = '0;
        stale_d = 1'b0;
      end else begin
        if (cnt_q != WIN) cnt_d = cnt_q + 1'b1;
        stale_d = (cnt_d == WIN);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  assign stale_o = stale_q;

endmodule

// File: rtl/wd_feeder.sv
// Watchdog feeder: feeds on a fixed cadence while all heartbeat sources are
// alive, and sequences a bounded recovery reset of the switch core on a trip.
module wd_feeder
  import wd_pkg::*;
#(
  parameter int N_SRC          = DEF_N_SRC,
  parameter int FEED_PERIOD    = DEF_FEED_PERIOD,
  parameter int FEED_WIDTH     = DEF_FEED_WIDTH,
  parameter int HB_WINDOW      = DEF_HB_WINDOW,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_SRC-1:0]  hb,
  input  logic              wdog,
  output logic              feed,
  output logic              sys_rst_n,
  output logic              recovering,
  output logic [N_SRC-1:0]  stale,
  output logic [TRIP_W-1:0] trip_cnt
);

  localparam int PW   = $clog2(FEED_PERIOD);
  localparam int TMAX = (FEED_WIDTH > RECOVER_CYCLES) ? FEED_WIDTH : RECOVER_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PER_LAST  = PW'(FEED_PERIOD - 1);
  localparam logic [TW-1:0] FEED_LAST = TW'(FEED_WIDTH - 1);
  localparam logic [TW-1:0] REC_LAST  = TW'(RECOVER_CYCLES - 1);

  function automatic logic [TRIP_W-1:0] sat_inc(input logic [TRIP_W-1:0] v);
    return (v == {TRIP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  wd_state_e         state_q, state_d;
  logic [PW-1:0]     per_q, per_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [TRIP_W-1:0] trip_q, trip_d;
  logic              feed_q, srst_n_q, rec_q;
  logic              hb_act, hb_clr;

  // Trip beats disable, disable beats a pending feed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (wdog)                                      state_d = ST_RECOVER;
        else if (!en)                                  state_d = ST_DISABLED;
        else if ((per_q == PER_LAST) && (stale == '0)) state_d = ST_FEED;
      end
      ST_FEED: begin
        if (wdog)                     state_d = ST_RECOVER;
        else if (!en)                 state_d = ST_DISABLED;
        else if (tmr_q == FEED_LAST)  state_d = ST_RUN;
      end
      ST_RECOVER: if (tmr_q == REC_LAST) state_d = ST_HOLDOFF;
      ST_HOLDOFF: if (!wdog) state_d = en ? ST_RUN : ST_DISABLED;
      default:    state_d = ST_DISABLED;
    endcase
  end

  // Period counter only runs inside an unbroken RUN stretch and parks on its
  // last value while feeding is withheld for a stale source.
  always_comb begin
    per_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN))
      per_d = (per_q == PER_LAST) ? per_q : per_q + 1'b1;
  end

  always_comb begin
    tmr_d = '0;
    if ((state_d == state_q) && ((state_q == ST_FEED) || (state_q == ST_RECOVER)))
      tmr_d = tmr_q + 1'b1;
  end

  assign trip_d = ((state_d == ST_RECOVER) && (state_q != ST_RECOVER)) ? sat_inc(trip_q) : trip_q;

  assign hb_act = (state_q == ST_RUN) || (state_q == ST_FEED);
  assign hb_clr = (state_q == ST_DISABLED) ||
                  ((state_q == ST_HOLDOFF) && (state_d != ST_HOLDOFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_DISABLED;
      per_q    <= '0;
      tmr_q    <= '0;
      trip_q   <= '0;
      feed_q   <= 1'b0;
      srst_n_q <= 1'b1;
      rec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      tmr_q    <= tmr_d;
      trip_q   <= trip_d;
      feed_q   <= (state_d == ST_FEED);
      srst_n_q <= (state_d != ST_RECOVER);
      rec_q    <= (state_d == ST_RECOVER) || (state_d == ST_HOLDOFF);
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_hb
    wd_hb_mon #(.HB_WINDOW(HB_WINDOW)) u_mon (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (hb_clr),
      .act_i   (hb_act),
      .hb_i    (hb[i]),
      .stale_o (stale[i])
    );
  end

  assign feed       = feed_q;
  assign sys_rst_n  = srst_n_q;
  assign recovering = rec_q;
  assign trip_cnt   = trip_q;

endmodule

// File: tb/tb_wd_feeder.sv
// Bench for wd_feeder: vector table, directed corner sequences and a random
// phase, all compared cycle by cycle against a behavioural model.
module tb_wd_feeder;

  localparam int N = 4, FP = 8, FW = 2, HBW = 20, RC = 4;
  localparam int M_OFF = 0, M_RUN = 1, M_FEED = 2, M_REC = 3, M_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n, en, wdog;
  logic [N-1:0] hb;
  logic feed, sys_rst_n, recovering;
  logic [N-1:0] stale;
  logic [7:0] trip_cnt;

  int checks = 0, failures = 0;

  int m_mode, m_age, m_left, m_trips;
  int m_idle[N];
  logic [N-1:0] m_stale;

  typedef struct {
    logic       e;
    logic [3:0] h;
    logic       w;
    int         n;
    logic       f;
    logic       sr;
    logic       rc;
    logic [7:0] tc;
  } vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;

  wd_feeder #(
    .N_SRC(N), .FEED_PERIOD(FP), .FEED_WIDTH(FW), .HB_WINDOW(HBW), .RECOVER_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hb(hb), .wdog(wdog),
    .feed(feed), .sys_rst_n(sys_rst_n), .recovering(recovering),
    .stale(stale), .trip_cnt(trip_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_age = 0; m_left = 0; m_trips = 0; m_stale = '0;
    for (int i = 0; i < N; i++) m_idle[i] = 0;
  endtask

  // One clock edge of the behavioural model, given the inputs seen at that edge.
  task automatic model_edge(input logic e, input logic [N-1:0] h, input logic w);
    int nm;
    nm = m_mode;
    case (m_mode)
      M_OFF: if (e) nm = M_RUN;
      M_RUN, M_FEED: begin
        if (w) nm = M_REC;
        else if (!e) nm = M_OFF;
        else if (m_mode == M_RUN && m_age == FP - 1 && m_stale == '0) nm = M_FEED;
        else if (m_mode == M_FEED && m_left == 1) nm = M_RUN;
      end
      M_REC:  if (m_left == 1) nm = M_HOLD;
      M_HOLD: if (!w) nm = e ? M_RUN : M_OFF;
      default: nm = M_OFF;
    endcase
    for (int i = 0; i < N; i++) begin
      if (m_mode == M_OFF || (m_mode == M_HOLD && nm != M_HOLD)) begin
        m_idle[i] = 0; m_stale[i] = 1'b0;
      end else if (m_mode == M_RUN || m_mode == M_FEED) begin
        if (h[i]) begin
          m_idle[i] = 0; m_stale[i] = 1'b0;
        end else begin
          if (m_idle[i] < HBW) m_idle[i]++;
          m_stale[i] = (m_idle[i] >= HBW);
        end
      end
    end
    if (m_mode == M_RUN && nm == M_RUN) m_age = (m_age < FP - 1) ? m_age + 1 : m_age;
    else m_age = 0;
    if (nm != m_mode) m_left = (nm == M_FEED) ? FW : (nm == M_REC) ? RC : 0;
    else if (m_left > 0) m_left--;
    if (nm == M_REC && m_mode != M_REC && m_trips < 255) m_trips++;
    m_mode = nm;
  endtask

  task automatic check_all();
    chk("model_feed", 32'(feed), 32'(m_mode == M_FEED));
    chk("model_sys_rst_n", 32'(sys_rst_n), 32'(m_mode != M_REC));
    chk("model_recovering", 32'(recovering), 32'(m_mode == M_REC || m_mode == M_HOLD));
    chk("model_stale", 32'(stale), 32'(m_stale));
    chk("model_trip_cnt", 32'(trip_cnt), 32'(m_trips));
  endtask

  task automatic step(input logic e, input logic [N-1:0] h, input logic w);
    en = e; hb = h; wdog = w;
    @(posedge clk);
    model_edge(e, h, w);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; hb = '0; wdog = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_feed", 32'(feed), 32'd0);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 32'd1);
    chk("rst_recovering", 32'(recovering), 32'd0);
    chk("rst_stale", 32'(stale), 32'd0);
    chk("rst_trip_cnt", 32'(trip_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int nf, nlow, nrec, got;
    int wd_left, off_left, sil_left, sil_src;
    logic re, rw;
    logic [N-1:0] rh;

    tbl[0]  = '{1'b0, 4'hF, 1'b0, 3, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 3, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 4'hF, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 4'hF, 1'b0, 7, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 4'hF, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 4'hF, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 4'hF, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 4'hF, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[8]  = '{1'b1, 4'hF, 1'b1, 3, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[9]  = '{1'b1, 4'hF, 1'b1, 1, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[10] = '{1'b1, 4'hF, 1'b1, 2, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[11] = '{1'b1, 4'hF, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 4'hF, 1'b0, 7, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[13] = '{1'b1, 4'hF, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[14] = '{1'b0, 4'hF, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[15] = '{1'b0, 4'hF, 1'b1, 2, 1'b0, 1'b1, 1'b0, 8'd1};

    do_reset();
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < tbl[r].n; k++) step(tbl[r].e, tbl[r].h, tbl[r].w);
      chk($sformatf("tbl%0d_feed", r), 32'(feed), 32'(tbl[r].f));
      chk($sformatf("tbl%0d_sys_rst_n", r), 32'(sys_rst_n), 32'(tbl[r].sr));
      chk($sformatf("tbl%0d_recovering", r), 32'(recovering), 32'(tbl[r].rc));
      chk($sformatf("tbl%0d_trip_cnt", r), 32'(trip_cnt), 32'(tbl[r].tc));
    end

    // Source 2 goes silent: stale after exactly 20 idle cycles, feeding stops.
    do_reset();
    repeat (30) step(1'b1, 4'hF, 1'b0);
    repeat (19) step(1'b1, 4'b1011, 1'b0);
    chk("stale_before_window", 32'(stale), 32'd0);
    step(1'b1, 4'b1011, 1'b0);
    chk("stale_at_window", 32'(stale), 32'b0100);
    repeat (2) step(1'b1, 4'b1011, 1'b0);
    nf = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 4'b1011, 1'b0);
      if (feed) nf++;
    end
    chk("stale_no_feed", 32'(nf), 32'd0);
    step(1'b1, 4'hF, 1'b0);
    chk("stale_cleared", 32'(stale), 32'd0);
    got = 0;
    for (int k = 0; k < 8 && got == 0; k++) begin
      step(1'b1, 4'hF, 1'b0);
      if (feed) got = 1;
    end
    chk("feed_resumes", 32'(got), 32'd1);

    // Trip coinciding with the last period count, then wdog held for 10 cycles.
    do_reset();
    step(1'b1, 4'hF, 1'b0);
    repeat (7) step(1'b1, 4'hF, 1'b0);
    chk("pre_trip_feed", 32'(feed), 32'd0);
    nlow = 0; nrec = 0; nf = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'hF, 1'b1);
      if (!sys_rst_n) nlow++;
      if (recovering) nrec++;
      if (feed) nf++;
      if (k == 0) chk("trip_first_sys_rst_n", 32'(sys_rst_n), 32'd0);
    end
    chk("trip_low_cycles", 32'(nlow), 32'(RC));
    chk("trip_recovering_cycles", 32'(nrec), 32'd10);
    chk("trip_no_feed", 32'(nf), 32'd0);
    chk("trip_count_one", 32'(trip_cnt), 32'd1);
    step(1'b1, 4'hF, 1'b0);
    chk("trip_released", 32'(recovering), 32'd0);

    // 260 trips saturate the counter; async reset mid-recovery clears it.
    do_reset();
    step(1'b1, 4'hF, 1'b0);
    for (int t = 0; t < 260; t++) begin
      step(1'b1, 4'hF, 1'b1);
      repeat (5) step(1'b1, 4'hF, 1'b0);
    end
    chk("trip_saturated", 32'(trip_cnt), 32'd255);
    step(1'b1, 4'hF, 1'b1);
    step(1'b1, 4'hF, 1'b0);
    chk("mid_rec_low", 32'(sys_rst_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_sys_rst_n", 32'(sys_rst_n), 32'd1);
    chk("async_trip_cnt", 32'(trip_cnt), 32'd0);
    chk("async_recovering", 32'(recovering), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random phase against the model.
    do_reset();
    wd_left = 0; off_left = 0; sil_left = 0; sil_src = 0;
    for (int c = 0; c < 3000; c++) begin
      if (wd_left == 0 && $urandom_range(0, 149) == 0) wd_left = $urandom_range(1, 12);
      if (off_left == 0 && $urandom_range(0, 199) == 0) off_left = $urandom_range(1, 5);
      if (sil_left == 0 && $urandom_range(0, 299) == 0) begin
        sil_src = $urandom_range(0, N - 1);
        sil_left = $urandom_range(15, 35);
      end
      rw = (wd_left > 0);
      re = (off_left == 0);
      for (int i = 0; i < N; i++)
        rh[i] = ($urandom_range(0, 5) == 0) && !(sil_left > 0 && sil_src == i);
      if (wd_left > 0) wd_left--;
      if (off_left > 0) off_left--;
      if (sil_left > 0) sil_left--;
      step(re, rh, rw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
